// File: rtl/pbc_pkg.sv
// Shared types for the parametrised bus CPU: opcodes, FSM states, ALU ops, bus sources.
package pbc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDI = 4'd1,
        OP_SUB  = 4'd2,
        OP_XOR  = 4'd3,
        OP_NAND = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_NOR  = 4'd8,
        OP_BEQ  = 4'd9,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_PC_UPD,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_NAND,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_NOR
    } alu_op_t;

    typedef enum logic [2:0] {
        BUS_NONE,
        BUS_RS1,
        BUS_RS2,
        BUS_IMM,
        BUS_ALU
    } bus_src_t;

    // ADDI shares the adder; non-ALU opcodes map to ADD but never write back.
    function automatic alu_op_t alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            OP_NAND: return ALU_NAND;
            OP_SLL:  return ALU_SLL;
            OP_SRL:  return ALU_SRL;
            OP_SRA:  return ALU_SRA;
            OP_NOR:  return ALU_NOR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_NOR;
    endfunction

endpackage

// File: rtl/pbc_alu.sv
// Combinational ALU for param_bus_cpu; all results wrap modulo 2^DATA_W.
module pbc_alu
    import pbc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;

    assign shamt = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_NAND: y = ~(a & b);
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = DATA_W'($signed(a) >>> shamt);
            ALU_NOR:  y = ~(a | b);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/param_bus_cpu.sv
// Multi-cycle single-bus CPU: FETCH, RD_A, RD_B, EXEC, PC_UPD, plus a terminal HALT state.
// Define PBC_BRANCH_EN to enable BEQ; without it opcode 9 behaves as a NOP.
module param_bus_cpu
    import pbc_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  NUM_REGS = 8,
    parameter int  PC_STEP  = 4,
    localparam int RA_W     = $clog2(NUM_REGS),
    localparam int INSTR_W  = 4 + 3 * RA_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  pc,
    output logic               halted,
    input  logic               dbg_sel,
    input  logic [RA_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t              state, state_next;
    bus_src_t            bus_src;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   a_reg, b_reg, bus, alu_y, pc_next;
    logic [DATA_W-1:0]   rf [NUM_REGS];
    logic [3:0]          op;
    logic [RA_W-1:0]     rs1, rs2, rd;
    logic                take_branch;

    assign op  = ir[3:0];
    assign rs2 = ir[4 +: RA_W];
    assign rs1 = ir[4 + RA_W +: RA_W];
    assign rd  = ir[4 + 2 * RA_W +: RA_W];

`ifdef PBC_BRANCH_EN
    assign take_branch = (op == OP_BEQ) && (a_reg == b_reg);
`else
    assign take_branch = 1'b0;
`endif

    assign pc_next     = take_branch ? DATA_W'({rd, rs2}) : pc + DATA_W'(PC_STEP);
    assign instr_ready = (state == S_FETCH);
    assign halted      = (state == S_HALT);
    assign dbg_data    = dbg_sel ? rf[dbg_addr] : pc;

    pbc_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op_of(op)),
        .a  (a_reg),
        .b  (b_reg),
        .y  (alu_y)
    );

    always_comb begin
        state_next = state;
        bus_src    = BUS_NONE;
        case (state)
            S_FETCH:  if (instr_valid) state_next = S_RD_A;
            S_RD_A: begin
                bus_src    = BUS_RS1;
                state_next = S_RD_B;
            end
            S_RD_B: begin
                bus_src    = (op == OP_ADDI) ? BUS_IMM : BUS_RS2;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (writes_rd(op)) bus_src = BUS_ALU;
                state_next = (op == OP_HALT) ? S_HALT : S_PC_UPD;
            end
            S_PC_UPD: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Exactly one source owns the bus each cycle; an idle bus reads as zero.
    always_comb begin
        bus = '0;
        case (bus_src)
            BUS_RS1: bus = rf[rs1];
            BUS_RS2: bus = rf[rs2];
            BUS_IMM: bus = DATA_W'(rs2);
            BUS_ALU: bus = alu_y;
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            ir    <= '0;
            a_reg <= '0;
            b_reg <= '0;
            pc    <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && instr_valid) ir <= instr;
            if (state == S_RD_A) a_reg <= bus;
            if (state == S_RD_B) b_reg <= bus;
            if (bus_src == BUS_ALU) rf[rd] <= bus;
            if (state == S_PC_UPD) pc <= pc_next;
        end
    end

endmodule
